// File: rtl/gpio_pkg.sv
// Shared definitions for the port-0 GPIO input capture block.
package gpio_pkg;

  localparam int unsigned GPIO_WIDTH = 16;

  localparam logic [1:0] GPIO_IN_ADDR_LEVEL     = 2'd0;
  localparam logic [1:0] GPIO_IN_ADDR_EVENT     = 2'd1;
  localparam logic [1:0] GPIO_IN_ADDR_RISE_MASK = 2'd2;
  localparam logic [1:0] GPIO_IN_ADDR_FALL_MASK = 2'd3;

endpackage

// File: rtl/gpio_p0_in_capture_if.sv
// CPU register bus for the GPIO input capture block.
interface gpio_p0_in_capture_if
  import gpio_pkg::*;
#(
  parameter int unsigned WIDTH = GPIO_WIDTH
);
  logic [1:0]       bus_addr;
  logic             bus_wr;
  logic [WIDTH-1:0] bus_wdata;
  logic             bus_rd;
  logic [WIDTH-1:0] bus_rdata;
  logic             bus_rd_valid;

  modport master (
    output bus_addr, bus_wr, bus_wdata, bus_rd,
    input  bus_rdata, bus_rd_valid
  );

  modport slave (
    input  bus_addr, bus_wr, bus_wdata, bus_rd,
    output bus_rdata, bus_rd_valid
  );
endinterface

// File: rtl/gpio_in_debounce_bit.sv
// One GPIO input bit: 2-flop synchronizer followed by either a sampled
// debouncer (GPIO_IN_DEBOUNCE_EN defined) or a direct enabled level register.
module gpio_in_debounce_bit
`ifdef GPIO_IN_DEBOUNCE_EN
#(
  parameter int unsigned DB_SAMPLES = 3
)
`endif
(
  input  logic clk,
  input  logic rst,
  input  logic pin,
`ifdef GPIO_IN_DEBOUNCE_EN
  input  logic tick,
`endif
  input  logic en,
  output logic level
);

  logic sync_meta;
  logic sync_q;

  // Synchronizer runs regardless of enable.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_meta <= 1'b0;
      sync_q    <= 1'b0;
    end else begin
      sync_meta <= pin;
      sync_q    <= sync_meta;
    end
  end

`ifdef GPIO_IN_DEBOUNCE_EN
  logic [DB_SAMPLES-1:0] hist;
  logic                  all_one;
  logic                  all_zero;

  assign all_one  = &hist;
  assign all_zero = ~|hist;

  // Shift the synchronized value into the history on each prescaler tick.
  always_ff @(posedge clk) begin
    if (!rst) begin
      hist <= '0;
    end else if (tick) begin
      hist <= {hist[DB_SAMPLES-2:0], sync_q};
    end
  end

  // Accept a new level only once the whole history agrees on it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      level <= 1'b0;
    end else if (en && ((all_one && !level) || (all_zero && level))) begin
      level <= all_one;
    end
  end
`else
  // Without debouncing the level follows the synchronizer while enabled.
  always_ff @(posedge clk) begin
    if (!rst) begin
      level <= 1'b0;
    end else if (en) begin
      level <= sync_q;
    end
  end
`endif

endmodule

// File: rtl/gpio_p0_in_capture.sv
// Port-0 GPIO input capture: per-bit sync/debounce, edge detection, sticky
// masked event flags, interrupt and a registered CPU register file.
// Optional macro GPIO_IN_DEBOUNCE_EN enables the prescaled debouncer.
module gpio_p0_in_capture
  import gpio_pkg::*;
#(
  parameter int unsigned WIDTH      = GPIO_WIDTH,
  parameter int unsigned DB_DIV     = 8,
  parameter int unsigned DB_SAMPLES = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     GPIO_0_pins,
  input  logic                 GPIO_0_In_En,
  gpio_p0_in_capture_if.slave  bus,
  output logic                 GPIO_In_IRQ
);

  if (DB_DIV < 1 || DB_SAMPLES < 2 || DB_SAMPLES > 8) begin : g_bad_cfg
    $error("gpio_p0_in_capture: DB_DIV must be >=1 and DB_SAMPLES 2..8");
  end

  logic [WIDTH-1:0] level;
  logic [WIDTH-1:0] level_prev;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] evt_flags;
  logic [WIDTH-1:0] evt_set;
  logic [WIDTH-1:0] evt_clr;
  logic [WIDTH-1:0] rise_mask;
  logic [WIDTH-1:0] fall_mask;
  logic [WIDTH-1:0] rd_mux;

`ifdef GPIO_IN_DEBOUNCE_EN
  localparam int unsigned CNT_W = (DB_DIV > 1) ? $clog2(DB_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_DIV - 1);

  logic [CNT_W-1:0] div_cnt;
  logic             tick;

  assign tick = GPIO_0_In_En && (div_cnt == CNT_LAST);

  // Shared debounce prescaler; holds while capture is disabled.
  always_ff @(posedge clk) begin
    if (!rst) begin
      div_cnt <= '0;
    end else if (GPIO_0_In_En) begin
      div_cnt <= tick ? '0 : div_cnt + 1'b1;
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    gpio_in_debounce_bit #(.DB_SAMPLES(DB_SAMPLES)) u_bit (
      .clk   (clk),
      .rst   (rst),
      .pin   (GPIO_0_pins[i]),
      .tick  (tick),
      .en    (GPIO_0_In_En),
      .level (level[i])
    );
  end
`else
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    gpio_in_debounce_bit u_bit (
      .clk   (clk),
      .rst   (rst),
      .pin   (GPIO_0_pins[i]),
      .en    (GPIO_0_In_En),
      .level (level[i])
    );
  end
`endif

  // Previous level, so edges pulse in the cycle the new level is visible.
  always_ff @(posedge clk) begin
    if (!rst) level_prev <= '0;
    else      level_prev <= level;
  end

  assign rise    = level & ~level_prev;
  assign fall    = ~level & level_prev;
  assign evt_set = (rise & rise_mask) | (fall & fall_mask);
  assign evt_clr = (bus.bus_wr && bus.bus_addr == GPIO_IN_ADDR_EVENT) ? bus.bus_wdata : '0;

  // Sticky event flags; a set in the same cycle as a W1C clear wins.
  always_ff @(posedge clk) begin
    if (!rst) evt_flags <= '0;
    else      evt_flags <= (evt_flags & ~evt_clr) | evt_set;
  end

  // Edge mask registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rise_mask <= '0;
      fall_mask <= '0;
    end else if (bus.bus_wr) begin
      if (bus.bus_addr == GPIO_IN_ADDR_RISE_MASK) rise_mask <= bus.bus_wdata;
      if (bus.bus_addr == GPIO_IN_ADDR_FALL_MASK) fall_mask <= bus.bus_wdata;
    end
  end

  // Read select from current (pre-write) register contents.
  always_comb begin
    rd_mux = '0;
    case (bus.bus_addr)
      GPIO_IN_ADDR_LEVEL:     rd_mux = level;
      GPIO_IN_ADDR_EVENT:     rd_mux = evt_flags;
      GPIO_IN_ADDR_RISE_MASK: rd_mux = rise_mask;
      GPIO_IN_ADDR_FALL_MASK: rd_mux = fall_mask;
      default:                rd_mux = '0;
    endcase
  end

  // Registered read port and interrupt.
  always_ff @(posedge clk) begin
    if (!rst) begin
      bus.bus_rdata    <= '0;
      bus.bus_rd_valid <= 1'b0;
      GPIO_In_IRQ      <= 1'b0;
    end else begin
      if (bus.bus_rd) bus.bus_rdata <= rd_mux;
      bus.bus_rd_valid <= bus.bus_rd;
      GPIO_In_IRQ      <= |evt_flags;
    end
  end

endmodule
